latency_mem_ctrl: RTL and testbench
===================================

LATENCY_MEM_CTRL -- requirements
Module: latency_mem_ctrl

Interface
REQ-001 SHALL have parameter NCELLS, default 16, number of latency memory cells served; legal values are 4 to 32.
REQ-002 SHALL have parameter IDXW, default 4, width of a cell index; it equals ceil(log2(NCELLS)).
REQ-003 SHALL have port Clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port HitValid, input, 1 bit: a new hit requests a cell in this cycle.
REQ-006 SHALL have port CellFull, input, NCELLS bits: Full flag of each cell.
REQ-007 SHALL have port CellReady, input, NCELLS bits: ReadyToRead flag of each cell.
REQ-008 SHALL have port WriteLe, output, NCELLS bits: one-hot write-enable to the allocated cell.
REQ-009 SHALL have port Read, output, NCELLS bits: one-hot read-release pulse to the cell being read.
REQ-010 SHALL have port RdValid, output, 1 bit: a readout offer is pending.
REQ-011 SHALL have port RdIdx, output, IDXW bits: index of the offered cell.
REQ-012 SHALL have port RdAck, input, 1 bit: the downstream consumer accepts the offer.
REQ-013 SHALL have port Overflow, output, 1 bit: one-cycle pulse when a hit is dropped.
REQ-014 SHALL have port OvfCnt, output, 8 bits: saturating count of dropped hits.
REQ-015 SHALL have port Occupancy, output, IDXW+1 bits: registered population count of CellFull.

Function -- write allocation
REQ-016 SHALL hold a write pointer WrPtr (IDXW bits, reset 0).
- Allocated cell = first index i, searched circularly from WrPtr, with CellFull[i]=0.
REQ-017 SHALL drive WriteLe combinationally in the same cycle as HitValid.
- WriteLe = one-hot of the allocated cell when HitValid=1 and a free cell exists.
- WriteLe = all zeros otherwise.
REQ-018 SHALL, on an allocating edge, load WrPtr with (allocated index + 1) mod NCELLS; otherwise WrPtr holds.
REQ-019 SHALL, when HitValid=1 and all CellFull bits are 1, drive WriteLe zero, assert Overflow for exactly the next cycle, and increment OvfCnt.
- OvfCnt saturates at 255; it never wraps.
REQ-020 SHALL register Occupancy each cycle as popcount(CellFull); it therefore lags CellFull by one cycle.

Function -- readout FSM (states IDLE, OFFER, READ)
REQ-021 SHALL, in IDLE, when any CellReady bit is 1, do the following on the edge and enter OFFER:
- select the first ready index searched circularly from RdPtr (IDXW bits, reset 0);
- register it into RdIdx;
- set RdValid=1.
REQ-022 SHALL, in OFFER, hold RdValid=1 and RdIdx stable until RdAck=1 is sampled.
- On that edge: enter READ, RdValid=0, Read = one-hot(RdIdx).
REQ-023 SHALL assert Read during READ for exactly one cycle, load RdPtr with (RdIdx + 1) mod NCELLS, and return to IDLE.
- RdValid stays 0 for at least one cycle, so the released cell can clear ReadyToRead.
REQ-024 SHALL, when CellReady[RdIdx] is 0 in OFFER with RdAck=0, withdraw the offer: RdValid=0, return to IDLE, no Read pulse.
REQ-025 SHALL give RdAck priority over withdrawal when both occur in the same cycle.
REQ-026 SHALL ignore RdAck in IDLE and READ.
REQ-027 SHALL keep the write and read paths independent: a hit and a read in the same cycle are both serviced, with no mutual stall.
REQ-028 SHALL guarantee WriteLe and Read are each at most one-hot in every cycle.

Reset
REQ-029 SHALL, while Reset=1, asynchronously force all of the following to zero:
- WrPtr, RdPtr, RdIdx, OvfCnt, Occupancy;
- RdValid, Overflow, Read;
- FSM state to IDLE.
REQ-030 SHALL force WriteLe to zero while Reset=1, regardless of HitValid.
REQ-031 SHALL, after a reset asserted mid-offer, emit no Read pulse and no RdValid until CellReady is again observed in IDLE.

Verification (NCELLS=4)
REQ-032 SHALL cover: CellFull=0000, HitValid for 3 cycles -> WriteLe 0001, 0010, 0100 (CellFull updated one cycle later by the cell model); WrPtr=3.
REQ-033 SHALL cover: CellFull=1111, HitValid pulsed 300 times -> WriteLe always 0; 300 one-cycle Overflow pulses; OvfCnt ends at 255.
REQ-034 SHALL cover: CellReady=0110, RdPtr=0, RdAck held 1 -> RdIdx=1 then Read=0010; afterwards RdIdx=2 then Read=0100; RdValid low at least one cycle between offers.
REQ-035 SHALL cover: OFFER on RdIdx=2, CellReady[2] dropped with RdAck=0 -> RdValid falls next cycle, Read stays 0000, FSM in IDLE.
REQ-036 SHALL cover: Reset asserted in OFFER with RdAck=1 in the same cycle -> Read never pulses; all outputs 0 asynchronously; first post-reset allocation gives WriteLe=0001.
REQ-037 SHALL cover: simultaneous HitValid (CellFull=1110) and RdAck in OFFER for RdIdx=2 -> WriteLe=0001 and Read=0100 on consecutive cycles, with no Overflow.

Source files
------------

// File: rtl/latency_mem_ctrl.sv
// Latency-memory controller: circular write allocation with overflow counting,
// and a three-state readout handshake that releases one cell per accepted offer.
module latency_mem_ctrl #(
    parameter int NCELLS = 16,
    parameter int IDXW   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              HitValid,
    input  logic [NCELLS-1:0] CellFull,
    input  logic [NCELLS-1:0] CellReady,
    output logic [NCELLS-1:0] WriteLe,
    output logic [NCELLS-1:0] Read,
    output logic              RdValid,
    output logic [IDXW-1:0]   RdIdx,
    input  logic              RdAck,
    output logic              Overflow,
    output logic [7:0]        OvfCnt,
    output logic [IDXW:0]     Occupancy
);

    localparam logic [IDXW:0] NCELLS_W = NCELLS[IDXW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        READ  = 2'd2
    } rd_state_t;

    function automatic logic [IDXW-1:0] inc_mod(input logic [IDXW-1:0] v);
        logic [IDXW:0] s;
        s = {1'b0, v} + {{IDXW{1'b0}}, 1'b1};
        if (s >= NCELLS_W) begin
            s = '0;
        end else begin
            s = s;
        end
        return s[IDXW-1:0];
    endfunction

    // Returns {found, index} of the first set bit at or after start, wrapping around.
    function automatic logic [IDXW:0] find_first(input logic [NCELLS-1:0] vec,
                                                 input logic [IDXW-1:0]   start);
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] sel;
        logic            found;
        idx   = start;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NCELLS; k++) begin
            if (!found && vec[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
            idx = inc_mod(idx);
        end
        return {found, sel};
    endfunction

    function automatic logic [NCELLS-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NCELLS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [IDXW:0] popcount(input logic [NCELLS-1:0] vec);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < NCELLS; i++) begin
            c = c + {{IDXW{1'b0}}, vec[i]};
        end
        return c;
    endfunction

    logic [IDXW-1:0] wr_ptr_r;
    logic [IDXW:0]   alloc_s;
    logic            alloc_ok_s;

    logic [IDXW-1:0]   rd_ptr_r;
    logic [IDXW:0]     rd_sel_s;
    rd_state_t         state_r;
    rd_state_t         state_s;
    logic [IDXW-1:0]   rd_idx_s;
    logic              rd_valid_s;
    logic [NCELLS-1:0] read_s;
    logic [IDXW-1:0]   rd_ptr_s;

    // Free-cell search and combinational write enable, suppressed during reset.
    always_comb begin
        alloc_s    = find_first(~CellFull, wr_ptr_r);
        alloc_ok_s = HitValid && alloc_s[IDXW] && !Reset;
        if (alloc_ok_s) begin
            WriteLe = onehot(alloc_s[IDXW-1:0]);
        end else begin
            WriteLe = '0;
        end
    end

    // Write pointer advance, overflow pulse/counter and occupancy register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_r  <= '0;
            Overflow  <= 1'b0;
            OvfCnt    <= 8'd0;
            Occupancy <= '0;
        end else begin
            Occupancy <= popcount(CellFull);
            if (alloc_ok_s) begin
                wr_ptr_r <= inc_mod(alloc_s[IDXW-1:0]);
                Overflow <= 1'b0;
            end else if (HitValid && !alloc_s[IDXW]) begin
                Overflow <= 1'b1;
                if (OvfCnt != 8'd255) begin
                    OvfCnt <= OvfCnt + 8'd1;
                end else begin
                    OvfCnt <= OvfCnt;
                end
            end else begin
                Overflow <= 1'b0;
            end
        end
    end

    // Readout FSM next-state and next-output decode.
    always_comb begin
        rd_sel_s   = find_first(CellReady, rd_ptr_r);
        state_s    = state_r;
        rd_idx_s   = RdIdx;
        rd_valid_s = 1'b0;
        read_s     = '0;
        rd_ptr_s   = rd_ptr_r;
        case (state_r)
            IDLE: begin
                if (rd_sel_s[IDXW]) begin
                    state_s    = OFFER;
                    rd_idx_s   = rd_sel_s[IDXW-1:0];
                    rd_valid_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OFFER: begin
                // Acceptance wins over a simultaneous drop of the ready flag.
                if (RdAck) begin
                    state_s = READ;
                    read_s  = onehot(RdIdx);
                end else if (!CellReady[RdIdx]) begin
                    state_s = IDLE;
                end else begin
                    rd_valid_s = 1'b1;
                end
            end
            READ: begin
                state_s  = IDLE;
                rd_ptr_s = inc_mod(RdIdx);
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Readout FSM state and registered handshake outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= IDLE;
            RdIdx    <= '0;
            RdValid  <= 1'b0;
            Read     <= '0;
            rd_ptr_r <= '0;
        end else begin
            state_r  <= state_s;
            RdIdx    <= rd_idx_s;
            RdValid  <= rd_valid_s;
            Read     <= read_s;
            rd_ptr_r <= rd_ptr_s;
        end
    end

endmodule

// File: tb/tb_latency_mem_ctrl.sv
// Directed self-checking bench for latency_mem_ctrl with four cells.
module tb_latency_mem_ctrl;

    logic       Clk;
    logic       Reset;
    logic       HitValid;
    logic [3:0] CellFull;
    logic [3:0] CellReady;
    logic [3:0] WriteLe;
    logic [3:0] Read;
    logic       RdValid;
    logic [1:0] RdIdx;
    logic       RdAck;
    logic       Overflow;
    logic [7:0] OvfCnt;
    logic [2:0] Occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    latency_mem_ctrl #(.NCELLS(4), .IDXW(2)) dut (
        .Clk(Clk), .Reset(Reset), .HitValid(HitValid), .CellFull(CellFull),
        .CellReady(CellReady), .WriteLe(WriteLe), .Read(Read), .RdValid(RdValid),
        .RdIdx(RdIdx), .RdAck(RdAck), .Overflow(Overflow), .OvfCnt(OvfCnt),
        .Occupancy(Occupancy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic test_reset();
        @(negedge Clk);
        HitValid = 1'b1;
        CellFull = 4'b0000;
        #1;
        n_checks++;
        if (WriteLe !== 4'b0000) begin n_fail++; $display("FAIL reset_writele: got %b want 0000", WriteLe); end
        n_checks++;
        if ({RdValid, Overflow, Read, RdIdx, OvfCnt, Occupancy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: RdValid=%b Overflow=%b Read=%b RdIdx=%0d OvfCnt=%0d Occ=%0d want all 0",
                     RdValid, Overflow, Read, RdIdx, OvfCnt, Occupancy);
        end
        @(negedge Clk);
        HitValid = 1'b0;
        Reset    = 1'b0;
    endtask

    task automatic test_alloc();
        logic [3:0] one;
        logic [3:0] full_model;
        one        = 4'b0001;
        full_model = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            HitValid = 1'b1;
            CellFull = full_model;
            #1;
            n_checks++;
            if (WriteLe !== (one << i)) begin n_fail++; $display("FAIL alloc_%0d: WriteLe=%b want %b", i, WriteLe, one << i); end
            full_model = full_model | (one << i);
        end
        @(negedge Clk);
        HitValid = 1'b0;
        CellFull = full_model;
        @(negedge Clk);
        n_checks++;
        if (Occupancy !== 3'd3) begin n_fail++; $display("FAIL alloc_occupancy: got %0d want 3", Occupancy); end
        n_checks++;
        if (WriteLe !== 4'b0000) begin n_fail++; $display("FAIL alloc_idle: WriteLe=%b want 0000", WriteLe); end
        // Pointer must sit at 3: with every cell free the next grant is cell 3, then wraps to 0.
        CellFull = 4'b0000;
        HitValid = 1'b1;
        #1;
        n_checks++;
        if (WriteLe !== 4'b1000) begin n_fail++; $display("FAIL alloc_wrptr3: WriteLe=%b want 1000", WriteLe); end
        @(negedge Clk);
        #1;
        n_checks++;
        if (WriteLe !== 4'b0001) begin n_fail++; $display("FAIL alloc_wrap: WriteLe=%b want 0001", WriteLe); end
        @(negedge Clk);
        HitValid = 1'b0;
    endtask

    task automatic test_overflow();
        int pulses;
        pulses   = 0;
        CellFull = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_gap_%0d: Overflow=%b want 0", i, Overflow); end
            HitValid = 1'b1;
            #1;
            n_checks++;
            if (WriteLe !== 4'b0000) begin n_fail++; $display("FAIL ovf_writele_%0d: WriteLe=%b want 0000", i, WriteLe); end
            @(negedge Clk);
            HitValid = 1'b0;
            if (Overflow === 1'b1) pulses++;
            if (i == 9) begin
                n_checks++;
                if (OvfCnt !== 8'd10) begin n_fail++; $display("FAIL ovf_cnt10: got %0d want 10", OvfCnt); end
            end
        end
        @(negedge Clk);
        n_checks++;
        if (pulses !== 300) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 300", pulses); end
        n_checks++;
        if (OvfCnt !== 8'd255) begin n_fail++; $display("FAIL ovf_saturate: got %0d want 255", OvfCnt); end
        n_checks++;
        if (Occupancy !== 3'd4) begin n_fail++; $display("FAIL ovf_occupancy: got %0d want 4", Occupancy); end
        CellFull = 4'b0000;
    endtask

    task automatic test_read_sequence();
        @(negedge Clk);
        CellReady = 4'b0110;
        RdAck     = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b1 || RdIdx !== 2'd1) begin n_fail++; $display("FAIL rd_offer1: RdValid=%b RdIdx=%0d want 1/1", RdValid, RdIdx); end
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0010 || RdValid !== 1'b0) begin n_fail++; $display("FAIL rd_read1: Read=%b RdValid=%b want 0010/0", Read, RdValid); end
        CellReady = 4'b0100;
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0000 || RdValid !== 1'b0) begin n_fail++; $display("FAIL rd_gap: Read=%b RdValid=%b want 0000/0", Read, RdValid); end
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b1 || RdIdx !== 2'd2) begin n_fail++; $display("FAIL rd_offer2: RdValid=%b RdIdx=%0d want 1/2", RdValid, RdIdx); end
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0100) begin n_fail++; $display("FAIL rd_read2: Read=%b want 0100", Read); end
        CellReady = 4'b0000;
        RdAck     = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0000 || RdValid !== 1'b0) begin n_fail++; $display("FAIL rd_done: Read=%b RdValid=%b want 0000/0", Read, RdValid); end
    endtask

    task automatic test_withdraw();
        // Read pointer is now 3; the only ready cell is 2.
        @(negedge Clk);
        CellReady = 4'b0100;
        RdAck     = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b1 || RdIdx !== 2'd2) begin n_fail++; $display("FAIL wd_offer: RdValid=%b RdIdx=%0d want 1/2", RdValid, RdIdx); end
        CellReady = 4'b0000;
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b0 || Read !== 4'b0000) begin n_fail++; $display("FAIL wd_drop: RdValid=%b Read=%b want 0/0000", RdValid, Read); end
        RdAck = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b0 || Read !== 4'b0000) begin n_fail++; $display("FAIL wd_idle: RdValid=%b Read=%b want 0/0000", RdValid, Read); end
        RdAck = 1'b0;
    endtask

    task automatic test_reset_mid_offer();
        @(negedge Clk);
        CellReady = 4'b0100;
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b1) begin n_fail++; $display("FAIL rst_offer: RdValid=%b want 1", RdValid); end
        RdAck = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({RdValid, Overflow, Read, RdIdx, OvfCnt, Occupancy, WriteLe} !== 23'd0) begin
            n_fail++;
            $display("FAIL rst_async: RdValid=%b Read=%b RdIdx=%0d OvfCnt=%0d Occ=%0d WriteLe=%b want all 0",
                     RdValid, Read, RdIdx, OvfCnt, Occupancy, WriteLe);
        end
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0000) begin n_fail++; $display("FAIL rst_noread: Read=%b want 0000", Read); end
        CellReady = 4'b0000;
        RdAck     = 1'b0;
        Reset     = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0000 || RdValid !== 1'b0) begin n_fail++; $display("FAIL rst_after: Read=%b RdValid=%b want 0000/0", Read, RdValid); end
        CellFull = 4'b0000;
        HitValid = 1'b1;
        #1;
        n_checks++;
        if (WriteLe !== 4'b0001) begin n_fail++; $display("FAIL rst_alloc: WriteLe=%b want 0001", WriteLe); end
        @(negedge Clk);
        HitValid = 1'b0;
    endtask

    task automatic test_simultaneous();
        // Write pointer is 1 and read pointer 0 here.
        CellFull  = 4'b0001;
        CellReady = 4'b0100;
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b1 || RdIdx !== 2'd2) begin n_fail++; $display("FAIL sim_offer: RdValid=%b RdIdx=%0d want 1/2", RdValid, RdIdx); end
        HitValid = 1'b1;
        CellFull = 4'b1110;
        RdAck    = 1'b1;
        #1;
        n_checks++;
        if (WriteLe !== 4'b0001) begin n_fail++; $display("FAIL sim_write: WriteLe=%b want 0001", WriteLe); end
        @(negedge Clk);
        HitValid  = 1'b0;
        CellFull  = 4'b1111;
        CellReady = 4'b0000;
        n_checks++;
        if (Read !== 4'b0100) begin n_fail++; $display("FAIL sim_read: Read=%b want 0100", Read); end
        n_checks++;
        if (Overflow !== 1'b0) begin n_fail++; $display("FAIL sim_noovf: Overflow=%b want 0", Overflow); end
        RdAck = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_ack_priority();
        // Read pointer is 3; cell 1 is the first ready one.
        CellReady = 4'b0010;
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (RdValid !== 1'b1 || RdIdx !== 2'd1) begin n_fail++; $display("FAIL prio_offer: RdValid=%b RdIdx=%0d want 1/1", RdValid, RdIdx); end
        CellReady = 4'b0000;
        RdAck     = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0010) begin n_fail++; $display("FAIL prio_read: Read=%b want 0010", Read); end
        RdAck = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Read !== 4'b0000) begin n_fail++; $display("FAIL prio_single: Read=%b want 0000", Read); end
    endtask

    initial begin
        Reset     = 1'b1;
        HitValid  = 1'b0;
        CellFull  = 4'b0000;
        CellReady = 4'b0000;
        RdAck     = 1'b0;
        test_reset();
        test_alloc();
        test_overflow();
        test_read_sequence();
        test_withdraw();
        test_reset_mid_offer();
        test_simultaneous();
        test_ack_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
